// File: rtl/grid_pkg.sv
// Shared constants and types for the maze tile-update receiver.
package grid_pkg;

    localparam int unsigned GRID_W     = 4;
    localparam int unsigned GRID_H     = 5;
    localparam int unsigned FRAME_BITS = 16;

    // MSB positions of the frame fields: [15:12] x, [11:8] y, [7:0] color
    localparam int unsigned X_MSB     = 15;
    localparam int unsigned Y_MSB     = 11;
    localparam int unsigned COLOR_MSB = 7;

    localparam logic [7:0] CLEAR_COLOR = 8'b000_000_00;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit
    } rx_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with optional rising-edge pulse.
module sync_edge #(
    parameter logic RESET_VAL = 1'b0,
    parameter bit   EDGE_EN   = 1'b0
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;

    // Synchronizer chain
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

    if (EDGE_EN) begin : g_edge
        logic prev_q;

        // Previous synchronized value for edge detection
        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                prev_q <= RESET_VAL;
            end else begin
                prev_q <= sync_q;
            end
        end

        assign rise_o = sync_q & ~prev_q;
    end else begin : g_no_edge
        assign rise_o = 1'b0;
    end

endmodule

// File: rtl/maze_grid_receiver.sv
// Serial tile-update receiver: shifts in 16-bit frames and writes the tile-color array
// that the VGA pixel logic reads.
module maze_grid_receiver #(
    parameter int unsigned GRID_W      = grid_pkg::GRID_W,
    parameter int unsigned GRID_H      = grid_pkg::GRID_H,
    parameter logic [7:0]  CLEAR_COLOR = grid_pkg::CLEAR_COLOR
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       sck_i,
    input  logic       mosi_i,
    input  logic       cs_n_i,
    input  logic [2:0] rd_x_i,
    input  logic [2:0] rd_y_i,
    output logic [7:0] rd_color_o,
    output logic       frame_done_o,
    output logic       busy_o,
    output logic [7:0] err_count_o
);

    import grid_pkg::*;

    logic sck_rise;
    logic mosi_s;
    logic cs_n_s;
    logic unused_sck_level;
    logic unused_mosi_rise;
    logic unused_cs_rise;

    sync_edge #(.RESET_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_sck (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .d_i      (sck_i),
        .q_o      (unused_sck_level),
        .rise_o   (sck_rise)
    );

    sync_edge #(.RESET_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_mosi (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .d_i      (mosi_i),
        .q_o      (mosi_s),
        .rise_o   (unused_mosi_rise)
    );

    // CS_N idles high so the synchronizer comes out of reset deselected
    sync_edge #(.RESET_VAL(1'b1), .EDGE_EN(1'b0)) u_sync_cs (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .d_i      (cs_n_i),
        .q_o      (cs_n_s),
        .rise_o   (unused_cs_rise)
    );

    rx_state_e               state_q, state_d;
    logic [4:0]              bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [7:0]              err_q, err_d;
    logic                    frame_done_q, frame_done_d;
    logic                    err_inc;
    logic                    commit_ok;
    logic [7:0]              grid_q [GRID_W][GRID_H];

    logic [3:0] fld_x;
    logic [3:0] fld_y;
    logic [7:0] fld_color;
    logic       in_range;
    logic       last_bit;

    assign fld_x     = shift_q[X_MSB -: 4];
    assign fld_y     = shift_q[Y_MSB -: 4];
    assign fld_color = shift_q[COLOR_MSB -: 8];
    assign in_range  = (32'(fld_x) < GRID_W) && (32'(fld_y) < GRID_H);
    assign last_bit  = (bit_cnt_q == 5'(FRAME_BITS - 1));

    // FSM next-state, shifter and error-event decode
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        err_inc   = 1'b0;
        commit_ok = 1'b0;
        unique case (state_q)
            StIdle: begin
                bit_cnt_d = 5'd0;
                if (!cs_n_s && sck_rise) begin
                    shift_d   = {shift_q[FRAME_BITS-2:0], mosi_s};
                    bit_cnt_d = 5'd1;
                    state_d   = StShift;
                end
            end
            StShift: begin
                // The final bit wins over a simultaneous CS_N release
                if (sck_rise && (!cs_n_s || last_bit)) begin
                    shift_d   = {shift_q[FRAME_BITS-2:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (last_bit) begin
                        state_d = StCommit;
                    end
                end else if (cs_n_s) begin
                    // Release with no bits after a commit is just the end of the window
                    if (bit_cnt_q != 5'd0) begin
                        err_inc = 1'b1;
                    end
                    bit_cnt_d = 5'd0;
                    state_d   = StIdle;
                end
            end
            StCommit: begin
                if (in_range) begin
                    commit_ok = 1'b1;
                end else begin
                    err_inc = 1'b1;
                end
                bit_cnt_d = 5'd0;
                if (!cs_n_s) begin
                    state_d = StShift;
                    // An edge here is the first bit of the next frame
                    if (sck_rise) begin
                        shift_d   = {shift_q[FRAME_BITS-2:0], mosi_s};
                        bit_cnt_d = 5'd1;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d   = StIdle;
                bit_cnt_d = 5'd0;
            end
        endcase

        err_d        = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
        frame_done_d = commit_ok;
    end

    // FSM and control registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= StIdle;
            bit_cnt_q    <= 5'd0;
            shift_q      <= '0;
            err_q        <= 8'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Tile-color array, written at the end of a valid COMMIT
    always_ff @(posedge CLOCK_50) begin
        for (int unsigned x = 0; x < GRID_W; x++) begin
            for (int unsigned y = 0; y < GRID_H; y++) begin
                if (reset) begin
                    grid_q[x][y] <= CLEAR_COLOR;
                end else if (commit_ok && (32'(fld_x) == x) && (32'(fld_y) == y)) begin
                    grid_q[x][y] <= fld_color;
                end
            end
        end
    end

    // Combinational read port; out-of-range coordinates read as CLEAR_COLOR
    always_comb begin
        rd_color_o = CLEAR_COLOR;
        for (int unsigned x = 0; x < GRID_W; x++) begin
            for (int unsigned y = 0; y < GRID_H; y++) begin
                if ((32'(rd_x_i) == x) && (32'(rd_y_i) == y)) begin
                    rd_color_o = grid_q[x][y];
                end
            end
        end
    end

    assign frame_done_o = frame_done_q;
    assign busy_o       = (state_q != StIdle);
    assign err_count_o  = err_q;

endmodule

// File: tb/tb_maze_grid_receiver.sv
// Directed bench for maze_grid_receiver: frames, back-to-back, range errors, aborts,
// mid-frame reset and error-counter saturation.
module tb_maze_grid_receiver;

    localparam int HALF = 4;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       sck      = 1'b0;
    logic       mosi     = 1'b0;
    logic       cs_n     = 1'b1;
    logic [2:0] rd_x     = 3'd0;
    logic [2:0] rd_y     = 3'd0;
    logic [7:0] rd_color;
    logic       frame_done;
    logic       busy;
    logic [7:0] err_count;

    int n_cmp  = 0;
    int n_bad  = 0;
    int fd_cnt = 0;
    int exp_err = 0;
    logic [7:0] exp_grid [4][5];

    maze_grid_receiver u_dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .sck_i        (sck),
        .mosi_i       (mosi),
        .cs_n_i       (cs_n),
        .rd_x_i       (rd_x),
        .rd_y_i       (rd_y),
        .rd_color_o   (rd_color),
        .frame_done_o (frame_done),
        .busy_o       (busy),
        .err_count_o  (err_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (frame_done) fd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic send_bits(input logic [15:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            sck  = 1'b0;
            mosi = f[15-i];
            cycles(HALF);
            sck = 1'b1;
            cycles(HALF);
        end
        sck = 1'b0;
        cycles(HALF + 2);
    endtask

    task automatic send_frame(input logic [15:0] f);
        cs_n = 1'b0;
        cycles(HALF);
        send_bits(f, 16);
        cs_n = 1'b1;
        cycles(6);
    endtask

    // Reference behaviour of one complete frame
    task automatic model_frame(input logic [15:0] f);
        int x;
        int y;
        x = int'(f[15:12]);
        y = int'(f[11:8]);
        if (x < 4 && y < 5) exp_grid[x][y] = f[7:0];
        else if (exp_err < 255) exp_err++;
    endtask

    task automatic model_clear();
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 5; y++)
                exp_grid[x][y] = 8'h00;
        exp_err = 0;
    endtask

    task automatic check_grid(input string tag);
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 5; y++) begin
                rd_x = 3'(x);
                rd_y = 3'(y);
                cycles(1);
                check_eq($sformatf("%s(%0d,%0d)", tag, x, y), 16'(rd_color), 16'(exp_grid[x][y]));
            end
        end
    endtask

    initial begin
        model_clear();
        cycles(3);
        reset = 1'b0;
        cycles(2);
        check_eq("reset_busy", 16'(busy), 16'd0);
        check_eq("reset_err", 16'(err_count), 16'd0);
        check_eq("reset_fd", 16'(frame_done), 16'd0);
        check_grid("reset_tile");

        // Single valid frame
        fd_cnt = 0;
        send_frame(16'h23E0);
        model_frame(16'h23E0);
        check_eq("single_fd", 16'(fd_cnt), 16'd1);
        check_eq("single_busy", 16'(busy), 16'd0);
        check_grid("single_tile");

        // Two frames in one CS window
        fd_cnt = 0;
        cs_n = 1'b0;
        cycles(HALF);
        send_bits(16'h001C, 16);
        send_bits(16'h3403, 16);
        cs_n = 1'b1;
        cycles(6);
        model_frame(16'h001C);
        model_frame(16'h3403);
        check_eq("b2b_fd", 16'(fd_cnt), 16'd2);
        check_eq("b2b_err", 16'(err_count), 16'(exp_err));
        check_grid("b2b_tile");
        rd_x = 3'd3; rd_y = 3'd5; cycles(1);
        check_eq("oor_read_y", 16'(rd_color), 16'h00);
        rd_x = 3'd4; rd_y = 3'd4; cycles(1);
        check_eq("oor_read_x", 16'(rd_color), 16'h00);

        // Out-of-range coordinates
        fd_cnt = 0;
        send_frame(16'h40FF);
        send_frame(16'h05FF);
        model_frame(16'h40FF);
        model_frame(16'h05FF);
        check_eq("oor_err", 16'(err_count), 16'd2);
        check_eq("oor_fd", 16'(fd_cnt), 16'd0);
        check_grid("oor_tile");

        // Abort after 9 bits, then a good frame
        cs_n = 1'b0;
        cycles(HALF);
        send_bits(16'hFFFF, 9);
        cs_n = 1'b1;
        cycles(6);
        exp_err++;
        check_eq("abort_err", 16'(err_count), 16'(exp_err));
        check_eq("abort_busy", 16'(busy), 16'd0);
        send_frame(16'h11FF);
        model_frame(16'h11FF);
        check_eq("post_abort_err", 16'(err_count), 16'(exp_err));
        check_grid("post_abort_tile");

        // Reset mid-frame
        cs_n = 1'b0;
        cycles(HALF);
        send_bits(16'hA5A5, 8);
        check_eq("mid_busy", 16'(busy), 16'd1);
        reset = 1'b1;
        cycles(1);
        check_eq("rst_busy", 16'(busy), 16'd0);
        check_eq("rst_err", 16'(err_count), 16'd0);
        reset = 1'b0;
        cs_n = 1'b1;
        cycles(6);
        model_clear();
        check_eq("rst_idle_busy", 16'(busy), 16'd0);
        check_grid("rst_tile");

        // Error counter saturation
        fd_cnt = 0;
        cs_n = 1'b0;
        cycles(HALF);
        for (int i = 0; i < 255; i++) send_bits(16'h40FF, 16);
        check_eq("sat_255", 16'(err_count), 16'h00FF);
        send_bits(16'h40FF, 16);
        cs_n = 1'b1;
        cycles(6);
        check_eq("sat_hold", 16'(err_count), 16'h00FF);
        check_eq("sat_fd", 16'(fd_cnt), 16'd0);
        check_grid("sat_tile");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
